// File: rtl/eth_tx_fsm.sv
// eth_tx_fsm: packet transmit controller between a port FIFO and a beat
// interface. Words are fetched into a 2-entry in-order skid buffer. The head
// entry is either discarded (orphan word outside a packet) or presented on
// the out* outputs until the downstream side accepts it.
//
// Ports
//   clk, rstn         clock, async active-low reset
//   fifo_empty        FIFO empty flag
//   fifo_data         FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en        FIFO pop request
//   tx_ready          downstream accepts the current beat
//   outvalid/outdata/outsop/outeop/outdest   current beat
//   err_orphan        pulse: non-sop word dropped while no packet is open
//   err_nested        pulse: sop presented while a packet is open
//   pkt_cnt           number of transferred eop beats (wraps)
//
// state  | meaning
// IDLE   | no open packet; non-sop head words are discarded
// IN_PKT | sop sent, eop not yet sent
module eth_tx_fsm #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_WIDTH = 66,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   input  logic                  tx_ready,
   output logic                  outvalid,
   output logic [DATA_WIDTH-1:0] outdata,
   output logic                  outsop,
   output logic                  outeop,
   output logic [31:0]           outdest,
   output logic                  err_orphan,
   output logic                  err_nested,
   output logic [CNT_WIDTH-1:0]  pkt_cnt
);

   typedef enum logic {IDLE, IN_PKT} state_t;

   state_t                state_q, state_d;
   logic [FIFO_WIDTH-1:0] ent0_q, ent0_d;
   logic [FIFO_WIDTH-1:0] ent1_q, ent1_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic                  run_q;
   logic                  nested_seen_q, nested_seen_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic       head_vld, head_sop, head_eop;
   logic       discard, xfer, pop;
   logic [1:0] pending;

   assign head_vld = (occ_q != 2'd0);
   assign head_sop = ent0_q[0];
   assign head_eop = ent0_q[FIFO_WIDTH-1];
   assign discard  = head_vld && (state_q == IDLE) && !head_sop;
   assign xfer     = outvalid && tx_ready;
   assign pop      = xfer || discard;
   // occupancy plus the word still on its way from the FIFO (max 3 fits)
   assign pending  = occ_q + {1'b0, inflight_q};

   always_comb begin
      outvalid   = head_vld && !discard;
      outdata    = outvalid ? ent0_q[DATA_WIDTH+32:33] : '0;
      outdest    = outvalid ? ent0_q[32:1] : '0;
      outsop     = outvalid && head_sop;
      outeop     = outvalid && head_eop;
      err_orphan = discard;
      // a nested sop may sit on the head for many stalled cycles; flag it once
      err_nested = outvalid && (state_q == IN_PKT) && head_sop && !nested_seen_q;
      pkt_cnt    = cnt_q;
      // run_q keeps the pop request off until the first edge after reset
      fifo_rd_en = run_q && !fifo_empty &&
                   ((pending < 2'd2) || ((pending == 2'd2) && xfer));
   end

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      case ({inflight_q, pop})
         2'b01: begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b10: begin
            if (occ_q == 2'd0) ent0_d = fifo_data;
            else               ent1_d = fifo_data;
            occ_d = occ_q + 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               ent0_d = fifo_data;
            end else begin
               ent0_d = ent1_q;
               ent1_d = fifo_data;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      nested_seen_d = nested_seen_q;
      inflight_d    = fifo_rd_en;
      if (xfer) begin
         state_d = head_eop ? IDLE : IN_PKT;
         if (head_eop) cnt_d = cnt_q + 1'b1;
      end
      if (pop)             nested_seen_d = 1'b0;
      else if (err_nested) nested_seen_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         ent0_q        <= '0;
         ent1_q        <= '0;
         occ_q         <= 2'd0;
         inflight_q    <= 1'b0;
         run_q         <= 1'b0;
         nested_seen_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         ent0_q        <= ent0_d;
         ent1_q        <= ent1_d;
         occ_q         <= occ_d;
         inflight_q    <= inflight_d;
         run_q         <= 1'b1;
         nested_seen_q <= nested_seen_d;
         cnt_q         <= cnt_d;
      end
   end

endmodule

// File: tb/tb_eth_tx_fsm.sv
// Testbench for eth_tx_fsm: emulated FIFO, packet-level reference model
// (expected beat/orphan sequence derived from the words pushed), directed
// scenarios with literal expectations, and a randomized phase.
module tb_eth_tx_fsm;

   logic        clk = 1'b0;
   logic        rstn;
   logic        fifo_empty;
   logic [65:0] fifo_data;
   logic        fifo_rd_en;
   logic        tx_ready;
   logic        outvalid;
   logic [31:0] outdata;
   logic        outsop, outeop;
   logic [31:0] outdest;
   logic        err_orphan, err_nested;
   logic [15:0] pkt_cnt;

   eth_tx_fsm dut (
      .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd_en(fifo_rd_en), .tx_ready(tx_ready), .outvalid(outvalid),
      .outdata(outdata), .outsop(outsop), .outeop(outeop), .outdest(outdest),
      .err_orphan(err_orphan), .err_nested(err_nested), .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          orphan;
      bit          nested;
      bit          sop;
      bit          eop;
      logic [31:0] data;
      logic [31:0] dest;
   } exp_t;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic [31:0] dest;
      bit          sop;
      bit          eop;
   } log_t;

   int          checks = 0;
   int          errors = 0;
   logic [65:0] fq[$];
   exp_t        eq[$];
   log_t        lg[$];
   bit          m_open = 0;
   bit          nested_seen = 0;
   logic [15:0] exp_cnt = 0;
   bit          pend = 0;
   logic [65:0] pend_word;
   int          popped = 0, consumed = 0;
   int          cyc = 0;
   int          orph_cnt = 0, nest_cnt = 0;
   bit          tx_ready_v = 1'b0;
   bit          s_valid, s_sop, s_eop, s_rd, s_orph, s_nest, s_ready;
   logic [31:0] s_data, s_dest;
   logic [15:0] s_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_word(input bit sop, input bit eop, input logic [31:0] dest,
                            input logic [31:0] data);
      exp_t e;
      fq.push_back({eop, data, dest, sop});
      e.orphan = !m_open && !sop;
      e.nested = m_open && sop;
      e.sop = sop; e.eop = eop; e.data = data; e.dest = dest;
      if (!e.orphan) m_open = !eop;
      eq.push_back(e);
   endtask

   // one clock cycle: drive at negedge, compare, then account for the edge
   task automatic cycle();
      bit xfer;
      log_t l;
      @(negedge clk);
      if (pend) begin
         fifo_data = pend_word;
         pend = 0;
      end else begin
         fifo_data = {2'($urandom), $urandom, $urandom};
      end
      fifo_empty = (fq.size() == 0);
      tx_ready   = tx_ready_v;
      #1;
      s_valid = outvalid; s_data = outdata; s_dest = outdest; s_sop = outsop;
      s_eop = outeop; s_rd = fifo_rd_en; s_orph = err_orphan; s_nest = err_nested;
      s_cnt = pkt_cnt; s_ready = tx_ready;
      if (s_valid) begin
         if (eq.size() == 0 || eq[0].orphan) begin
            chk("unexpected_beat", 1, 0);
         end else begin
            chk("outdata", s_data, eq[0].data);
            chk("outdest", s_dest, eq[0].dest);
            chk("outsop", s_sop, eq[0].sop);
            chk("outeop", s_eop, eq[0].eop);
            chk("err_nested", s_nest, eq[0].nested && !nested_seen);
         end
      end else begin
         chk("err_nested_novalid", s_nest, 0);
      end
      if (s_orph) begin
         chk("orphan_kind", (eq.size() > 0) && eq[0].orphan, 1);
         orph_cnt++;
      end
      if (s_nest) nest_cnt++;
      chk("pkt_cnt", s_cnt, exp_cnt);
      if (s_rd) chk("rd_while_empty", fifo_empty, 0);
      chk("occupancy_le2", (popped - consumed) <= 2, 1);
      xfer = s_valid && s_ready;
      @(posedge clk);
      if (s_rd && fq.size() > 0) begin
         pend_word = fq.pop_front();
         pend = 1;
         popped++;
      end
      if (xfer && eq.size() > 0 && !eq[0].orphan) begin
         l.cyc = cyc; l.data = s_data; l.dest = s_dest; l.sop = s_sop; l.eop = s_eop;
         lg.push_back(l);
         if (eq[0].eop) exp_cnt = exp_cnt + 16'd1;
         void'(eq.pop_front());
         consumed++;
         nested_seen = 0;
      end else if (s_orph && eq.size() > 0 && eq[0].orphan) begin
         void'(eq.pop_front());
         consumed++;
         nested_seen = 0;
      end else if (s_nest) begin
         nested_seen = 1;
      end
      cyc++;
   endtask

   task automatic drain(input string name);
      int n = 0;
      tx_ready_v = 1'b1;
      while ((eq.size() != 0 || fq.size() != 0 || pend) && n < 500) begin
         cycle();
         n++;
      end
      if (n >= 500) chk({name, "_drain_timeout"}, 1, 0);
      repeat (2) cycle();
   endtask

   task automatic wait_log(input int cnt, input string name);
      int n = 0;
      while (lg.size() < cnt && n < 50) begin
         cycle();
         n++;
      end
      if (n >= 50) chk({name, "_wait_timeout"}, 1, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_en"}, fifo_rd_en, 0);
      chk({tag, "_outvalid"}, outvalid, 0);
      chk({tag, "_outdata"}, outdata, 0);
      chk({tag, "_outsop"}, outsop, 0);
      chk({tag, "_outeop"}, outeop, 0);
      chk({tag, "_outdest"}, outdest, 0);
      chk({tag, "_err_orphan"}, err_orphan, 0);
      chk({tag, "_err_nested"}, err_nested, 0);
      chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
   endtask

   initial begin
      int c0, o0, n0;
      rstn = 1'b0; fifo_empty = 1'b1; fifo_data = '0; tx_ready = 1'b0;
      #3;
      chk_zero("reset");
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // three-beat packet, back to back
      lg.delete();
      push_word(1, 0, 32'hABCD, 32'h1111);
      push_word(0, 0, 32'hABCD, 32'h2222);
      push_word(0, 1, 32'hABCD, 32'h3333);
      c0 = cyc;
      drain("p3");
      chk("p3_beats", lg.size(), 3);
      if (lg.size() == 3) begin
         chk("p3_lat", lg[0].cyc, c0 + 2);
         chk("p3_b2_cyc", lg[1].cyc, c0 + 3);
         chk("p3_b3_cyc", lg[2].cyc, c0 + 4);
         chk("p3_d0", lg[0].data, 32'h1111);
         chk("p3_d1", lg[1].data, 32'h2222);
         chk("p3_d2", lg[2].data, 32'h3333);
         chk("p3_sop", {lg[0].sop, lg[1].sop, lg[2].sop}, 3'b100);
         chk("p3_eop", {lg[0].eop, lg[1].eop, lg[2].eop}, 3'b001);
         chk("p3_dest", lg[0].dest, 32'hABCD);
      end
      chk("p3_cnt", s_cnt, 1);

      // stall for 4 cycles after the first beat
      lg.delete();
      push_word(1, 0, 32'h5, 32'h1111);
      push_word(0, 0, 32'h5, 32'h2222);
      push_word(0, 1, 32'h5, 32'h3333);
      push_word(1, 1, 32'h6, 32'h4444);
      tx_ready_v = 1'b1;
      wait_log(1, "stall");
      tx_ready_v = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("stall_valid", s_valid, 1);
         chk("stall_data", s_data, 32'h2222);
         chk("stall_rd_low", s_rd, 0);
      end
      drain("stall");
      chk("stall_beats", lg.size(), 4);
      if (lg.size() == 4) begin
         chk("stall_d1", lg[1].data, 32'h2222);
         chk("stall_d2", lg[2].data, 32'h3333);
         chk("stall_d3", lg[3].data, 32'h4444);
      end
      chk("stall_cnt", s_cnt, 3);

      // orphan word then single-beat packet
      lg.delete();
      o0 = orph_cnt;
      push_word(0, 0, 32'h0, 32'hDEAD);
      push_word(1, 1, 32'h7, 32'hBEEF);
      drain("orph");
      chk("orph_pulses", orph_cnt - o0, 1);
      chk("orph_beats", lg.size(), 1);
      if (lg.size() == 1) begin
         chk("orph_data", lg[0].data, 32'hBEEF);
         chk("orph_sopeop", {lg[0].sop, lg[0].eop}, 2'b11);
      end
      chk("orph_cnt", s_cnt, 4);

      // nested sop
      lg.delete();
      n0 = nest_cnt;
      push_word(1, 0, 32'h8, 32'hA0);
      push_word(1, 1, 32'h8, 32'hB0);
      drain("nest");
      chk("nest_pulses", nest_cnt - n0, 1);
      chk("nest_beats", lg.size(), 2);
      if (lg.size() == 2) begin
         chk("nest_d", {lg[0].data, lg[1].data}, {32'hA0, 32'hB0});
         chk("nest_sop", {lg[0].sop, lg[1].sop}, 2'b11);
      end
      chk("nest_cnt", s_cnt, 5);

      // reset in the middle of a packet
      lg.delete();
      push_word(1, 0, 32'h9, 32'hC1);
      push_word(0, 0, 32'h9, 32'hC2);
      push_word(0, 1, 32'h9, 32'hC3);
      tx_ready_v = 1'b1;
      wait_log(2, "rst");
      #2 rstn = 1'b0;
      #1;
      chk_zero("midrst");
      fq.delete(); eq.delete(); lg.delete();
      pend = 0; popped = 0; consumed = 0; exp_cnt = 0; m_open = 0; nested_seen = 0;
      push_word(1, 1, 32'hD, 32'hD5);
      fifo_empty = 1'b0;
      fifo_data  = {1'b1, 32'h0BAD, 32'h0BAD, 1'b1};
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("rel_rd_en", fifo_rd_en, 0);
      drain("rel");
      chk("rel_beats", lg.size(), 1);
      if (lg.size() == 1) chk("rel_data", lg[0].data, 32'hD5);
      chk("rel_cnt", s_cnt, 1);

      // counter wrap: 65534 more singles reach 65535, one more wraps to 0
      tx_ready_v = 1'b1;
      for (int i = 0; i < 65534; i++) begin
         push_word(1, 1, i, i);
         cycle();
      end
      drain("wrap_a");
      chk("wrap_max", s_cnt, 16'hFFFF);
      push_word(1, 1, 32'h1, 32'h1);
      drain("wrap_b");
      chk("wrap_zero", s_cnt, 0);
      lg.delete();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (fq.size() < 8 && $urandom_range(0, 99) < 60)
            push_word($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
                      $urandom, $urandom);
         tx_ready_v = ($urandom_range(0, 99) < 70);
         cycle();
      end
      drain("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
